// File: rtl/mux_pkg.sv
// Shared constants, select type and range helper for the 8-input, 1-bit multiplexer family.
package mux_pkg;

  localparam int MUX8_N_IN  = 8;
  localparam int MUX8_SEL_W = 3;

  typedef logic [MUX8_SEL_W-1:0] mux8_sel_t;

  // True when the index addresses an existing channel. This is only false when
  // the channel count is not a power of two.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return (sel < n);
  endfunction

endpackage

// File: rtl/mux_sel_reg.sv
// Enable/valid output register for the selected bit. It only exists when
// MUX_8BIT_PROCEDURAL_OUT_REG_EN is defined; otherwise this file is empty.
`ifdef MUX_8BIT_PROCEDURAL_OUT_REG_EN
module mux_sel_reg (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic vld
);

  logic data_d, data_q;
  logic vld_d, vld_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    data_d = data_q;
    vld_d  = 1'b0;
    if (en) begin
      data_d = d;
      vld_d  = 1'b1;
    end
  end

  // Reset wins over enable on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      data_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q   = data_q;
  assign vld = vld_q;

endmodule
`endif

// File: rtl/mux_8bit_procedural.sv
// N_IN-to-1 bit multiplexer with a selection error flag and an optional registered
// copy of the selected bit (enabled by defining MUX_8BIT_PROCEDURAL_OUT_REG_EN).
module mux_8bit_procedural
  import mux_pkg::*;
#(
  parameter int N_IN  = MUX8_N_IN,
  parameter int SEL_W = MUX8_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic             out,
  output logic             out_q,
  output logic             out_vld,
  output logic             sel_err
);

  if ((N_IN < 2) || (N_IN > 256) || (SEL_W != $clog2(N_IN))) begin : g_bad_params
    $error("mux_8bit_procedural: N_IN must be 2..256 and SEL_W must equal clog2(N_IN)");
  end

  logic sel_ok;
  logic sel_bit;

  assign sel_ok = sel_in_range(32'(sel), N_IN);

  // Indices past the last channel fall through to the zero default.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (sel == SEL_W'(i)) sel_bit = in[i];
    end
  end

  assign out     = sel_bit;
  assign sel_err = ~sel_ok;

`ifdef MUX_8BIT_PROCEDURAL_OUT_REG_EN
  mux_sel_reg u_sel_reg (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (sel_bit),
    .q   (out_q),
    .vld (out_vld)
  );
`else
  // Pass-through build: the register is removed and the clock and reset are unused.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};
  assign out_q          = sel_bit;
  assign out_vld        = en;
`endif

endmodule

// File: tb/tb_mux_8bit_procedural.sv
// Directed bench for mux_8bit_procedural: expected bits are queued when stimulus is
// driven and popped when the outputs are sampled. Covers both build configurations.
module tb_mux_8bit_procedural;
  import mux_pkg::*;

`ifdef MUX_8BIT_PROCEDURAL_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  mux8_sel_t  sel;
  logic       en;
  logic       out, out_q, out_vld, sel_err;

  logic [5:0] in6;
  logic [2:0] sel6;
  logic       out6, out_q6, out_vld6, sel_err6;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    logic  exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux_8bit_procedural u_dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .sel     (sel),
    .en      (en),
    .out     (out),
    .out_q   (out_q),
    .out_vld (out_vld),
    .sel_err (sel_err)
  );

  mux_8bit_procedural #(.N_IN(6), .SEL_W(3)) u_dut6 (
    .clk     (clk),
    .rst     (rst),
    .in      (in6),
    .sel     (sel6),
    .en      (en),
    .out     (out6),
    .out_q   (out_q6),
    .out_vld (out_vld6),
    .sel_err (sel_err6)
  );

  task automatic push(input string tag, input logic exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0b expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    pat  = 8'b10011010;
    rst  = 1'b1;
    en   = 1'b0;
    in   = 8'h00;
    sel  = '0;
    in6  = 6'h00;
    sel6 = 3'd0;

    // Reset state with enable low: registered path cleared, pass-through shows in[0]=0.
    push("rst_idle_q", 1'b0);
    push("rst_idle_vld", 1'b0);
    tick();
    tick();
    check(out_q);
    check(out_vld);

    // Combinational sweep, one select value every 5 ns.
    rst = 1'b0;
    in  = pat;
    for (int i = 0; i < 8; i++) begin
      sel = mux8_sel_t'(i);
      push($sformatf("sweep_out_sel%0d", i), pat[i]);
      push($sformatf("sweep_err_sel%0d", i), 1'b0);
      push($sformatf("sweep_q_sel%0d", i), REG ? 1'b0 : pat[i]);
      #1;
      check(out);
      check(sel_err);
      check(out_q);
      #4;
    end

    // Pass-through build reflects en immediately; registered build waits for an edge.
    tick();
    sel = 3'd4;
    en  = 1'b1;
    push("immediate_q", REG ? 1'b0 : 1'b1);
    push("immediate_vld", REG ? 1'b0 : 1'b1);
    #1;
    check(out_q);
    check(out_vld);
    en = 1'b0;

    // Data toggles on a fixed select with no clock involvement.
    sel = 3'd3;
    for (int i = 0; i < 4; i++) begin
      in = (i % 2 == 0) ? 8'h08 : 8'h00;
      push($sformatf("toggle_out_%0d", i), (i % 2 == 0) ? 1'b1 : 1'b0);
      #2;
      check(out);
    end

    // Reset has priority over a concurrent enable.
    tick();
    rst = 1'b1;
    en  = 1'b1;
    in  = 8'hFF;
    sel = 3'd5;
    for (int c = 0; c < 2; c++) begin
      push($sformatf("rst_pri_q_%0d", c), REG ? 1'b0 : 1'b1);
      push($sformatf("rst_pri_vld_%0d", c), REG ? 1'b0 : 1'b1);
      tick();
      check(out_q);
      check(out_vld);
    end
    rst = 1'b0;
    push("first_sample_q", 1'b1);
    push("first_sample_vld", 1'b1);
    tick();
    check(out_q);
    check(out_vld);

    // One-cycle enable pulse, then the data drops with enable low.
    sel = 3'd7;
    in  = 8'h80;
    push("pulse_q", 1'b1);
    push("pulse_vld", 1'b1);
    tick();
    check(out_q);
    check(out_vld);
    en = 1'b0;
    in = 8'h00;
    for (int c = 0; c < 2; c++) begin
      push($sformatf("hold_one_q_%0d", c), REG ? 1'b1 : 1'b0);
      push($sformatf("hold_one_vld_%0d", c), 1'b0);
      tick();
      check(out_q);
      check(out_vld);
    end

    // Capture a zero, then raise the data with enable low.
    en = 1'b1;
    push("cap_zero_q", 1'b0);
    push("cap_zero_vld", 1'b1);
    tick();
    check(out_q);
    check(out_vld);
    en = 1'b0;
    in = 8'h80;
    push("hold_zero_q", REG ? 1'b0 : 1'b1);
    push("hold_zero_vld", 1'b0);
    tick();
    check(out_q);
    check(out_vld);

    // Mid-stream reset clears the path; the next enabled edge yields a sample again.
    en  = 1'b1;
    in  = 8'h01;
    sel = 3'd0;
    rst = 1'b1;
    push("mid_rst_q", REG ? 1'b0 : 1'b1);
    push("mid_rst_vld", REG ? 1'b0 : 1'b1);
    tick();
    check(out_q);
    check(out_vld);
    rst = 1'b0;
    push("post_rst_q", 1'b1);
    push("post_rst_vld", 1'b1);
    tick();
    check(out_q);
    check(out_vld);

    // Six-channel instance: last legal channel, then both out-of-range indices.
    in6  = 6'h3F;
    sel6 = 3'd5;
    push("n6_sel5_out", 1'b1);
    push("n6_sel5_err", 1'b0);
    push("n6_sel5_q", 1'b1);
    tick();
    check(out6);
    check(sel_err6);
    check(out_q6);
    for (int s = 6; s < 8; s++) begin
      sel6 = 3'(s);
      push($sformatf("n6_sel%0d_out", s), 1'b0);
      push($sformatf("n6_sel%0d_err", s), 1'b1);
      push($sformatf("n6_sel%0d_q", s), 1'b0);
      push($sformatf("n6_sel%0d_vld", s), 1'b1);
      tick();
      check(out6);
      check(sel_err6);
      check(out_q6);
      check(out_vld6);
    end
    en = 1'b0;

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
